// File: rtl/keypad_unit_pkg.sv
// Shared definitions for the keypad block: entry-FSM states, key function codes
// and the scan-code to key-symbol map.
package keypad_unit_pkg;

  localparam int ISA_WIDTH         = 32;
  localparam int KEYPAD_MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    KP_IDLE  = 2'd0,
    KP_INPUT = 2'd1,
    KP_DONE  = 2'd2
  } kp_state_e;

  localparam logic [3:0] KEY_BACKSPACE = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hD;
  localparam logic [3:0] KEY_PAUSE     = 4'hE;

  // Symbols 0..9 are digits; 4'hC (C) and 4'hF (#) carry no function.
  function automatic logic [3:0] key_symbol(input logic [3:0] code);
    case (code)
      4'd0:    key_symbol = 4'h1;
      4'd1:    key_symbol = 4'h2;
      4'd2:    key_symbol = 4'h3;
      4'd3:    key_symbol = KEY_BACKSPACE;
      4'd4:    key_symbol = 4'h4;
      4'd5:    key_symbol = 4'h5;
      4'd6:    key_symbol = 4'h6;
      4'd7:    key_symbol = KEY_CLEAR;
      4'd8:    key_symbol = 4'h7;
      4'd9:    key_symbol = 4'h8;
      4'd10:   key_symbol = 4'h9;
      4'd11:   key_symbol = 4'hC;
      4'd12:   key_symbol = KEY_PAUSE;
      4'd13:   key_symbol = 4'h0;
      4'd14:   key_symbol = 4'hF;
      default: key_symbol = KEY_ENTER;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Drives the 4x4 matrix one row at a time, builds a raw key map per frame,
// debounces it and emits a single key_valid pulse per clean single-key press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] keypad_row,
  input  logic [3:0] keypad_col,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  logic [3:0]       col_meta_q, col_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [3:0]       row_q, row_d;
  logic [15:0]      acc_q, acc_d, prev_q, prev_d, stable_q, stable_d;
  logic [DB_W-1:0]  match_q, match_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             slot_end;

  assign slot_end = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch).
    div_d       = div_q + 1'b1;
    row_idx_d   = row_idx_q;
    row_d       = row_q;
    acc_d       = acc_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    match_d     = match_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    if (slot_end) begin
      div_d     = '0;
      row_idx_d = row_idx_q + 2'd1;
      row_d     = {row_q[2:0], row_q[3]};
      acc_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
      if (row_idx_q == 2'd3) begin
        prev_d = acc_d;
        if (acc_d == prev_q) begin
          if (match_q != DB_TARGET) match_d = match_q + 1'b1;
          if (match_d == DB_TARGET) stable_d = acc_d;
        end else begin
          match_d = '0;
        end
        // Only an all-clear -> exactly-one-key transition is a press.
        if (stable_q == '0 && stable_d != '0 && (stable_d & (stable_d - 16'd1)) == '0) begin
          key_valid_d = 1'b1;
          for (int i = 0; i < 16; i++) begin
            if (stable_d[i]) key_code_d = 4'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments; reset is synchronous here.
    if (rst) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      div_q       <= '0;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      acc_q       <= '0;
      prev_q      <= '0;
      stable_q    <= '0;
      match_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      col_meta_q  <= keypad_col;
      col_sync_q  <= col_meta_q;
      div_q       <= div_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      match_q     <= match_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign keypad_row = row_q;
  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;

endmodule

// File: rtl/keypad_unit.sv
// Keypad front end: decodes debounced presses into decimal number entry for
// data_mem and a pause/resume toggle for hazard_unit.
module keypad_unit
  import keypad_unit_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 20,
  parameter int MAX_DIGITS     = KEYPAD_MAX_DIGITS
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [3:0]           keypad_row,
  input  logic [3:0]           keypad_col,
  input  logic                 keypad_read_enable,
  output logic                 keypad_read_complete,
  output logic [ISA_WIDTH-1:0] keypad_value,
  output logic [3:0]           keypad_digit_cnt,
  output logic                 cpu_pause,
  output logic                 cpu_resume
);

  logic                 key_valid;
  logic [3:0]           key_code, sym;
  logic                 is_digit;
  kp_state_e            state_q, state_d;
  logic [ISA_WIDTH-1:0] value_q, value_d, value_x10, value_div10;
  logic [3:0]           cnt_q, cnt_d;
  logic                 complete_q, complete_d;
  logic                 pause_q, pause_d, paused_q, paused_d;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .keypad_row(keypad_row),
    .keypad_col(keypad_col),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  assign sym         = key_symbol(key_code);
  assign is_digit    = (sym <= 4'd9);
  // MAX_DIGITS bounds the value, so the shift-add can never overflow.
  assign value_x10   = (value_q << 3) + (value_q << 1) + ISA_WIDTH'(sym);
  assign value_div10 = value_q / ISA_WIDTH'(10);

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    cnt_d      = cnt_q;
    complete_d = complete_q;
    pause_d    = 1'b0;
    paused_d   = paused_q;
    case (state_q)
      KP_IDLE: begin
        if (keypad_read_enable) begin
          state_d = KP_INPUT;
          value_d = '0;
          cnt_d   = '0;
        end
      end
      KP_INPUT: begin
        if (!keypad_read_enable) begin
          state_d = KP_IDLE;
          value_d = '0;
          cnt_d   = '0;
        end else if (key_valid) begin
          if (is_digit) begin
            if (cnt_q < 4'(MAX_DIGITS)) begin
              value_d = value_x10;
              cnt_d   = cnt_q + 4'd1;
            end
          end else begin
            case (sym)
              KEY_BACKSPACE: if (cnt_q != 4'd0) begin
                value_d = value_div10;
                cnt_d   = cnt_q - 4'd1;
              end
              KEY_CLEAR: begin
                value_d = '0;
                cnt_d   = '0;
              end
              KEY_ENTER: begin
                state_d    = KP_DONE;
                complete_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      KP_DONE: begin
        if (!keypad_read_enable) begin
          state_d    = KP_IDLE;
          complete_d = 1'b0;
          value_d    = '0;
          cnt_d      = '0;
        end
      end
      default: state_d = KP_IDLE;
    endcase
    // Pause toggles independently of whatever the entry FSM is doing.
    if (key_valid && sym == KEY_PAUSE) begin
      pause_d  = ~paused_q;
      paused_d = ~paused_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= KP_IDLE;
      value_q    <= '0;
      cnt_q      <= '0;
      complete_q <= 1'b0;
      pause_q    <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      cnt_q      <= cnt_d;
      complete_q <= complete_d;
      pause_q    <= pause_d;
      paused_q   <= paused_d;
    end
  end

  assign keypad_read_complete = complete_q;
  assign keypad_value         = value_q;
  assign keypad_digit_cnt     = cnt_q;
  assign cpu_pause            = pause_q;
  assign cpu_resume           = ~paused_q;

endmodule
